// File: rtl/srt4_divider_pkg.sv
// Shared definitions for the radix-4 SRT divider.
// Contents: op encodings, FSM state enum, QDS interface widths and the
// one-hot digit bit positions in QDS output order {+2,+1,0,-1,-2}.
package srt4_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ITER,
    S_POST,
    S_DONE
  } state_e;

  localparam int QDS_W_W   = 7;
  localparam int QDS_DIV_W = 3;
  localparam int QDS_Q_W   = 5;

  localparam int DIG_P2 = 4;
  localparam int DIG_P1 = 3;
  localparam int DIG_Z  = 2;
  localparam int DIG_M1 = 1;
  localparam int DIG_M2 = 0;

endpackage

// File: rtl/QDS.sv
// Radix-4 SRT quotient-digit selection, digit set {-2..+2}.
// Ports:
//   w   [6:0] : truncated 4w estimate, two's complement, weights 2^2..2^-4
//   div [2:0] : normalised divisor bits at weights 2^-2..2^-4
//   q   [4:0] : one-hot digit, bit 4 = +2 ... bit 0 = -2
// Thresholds are in units of 1/16 and hold for a non-redundant residual
// with |w| <= 2/3 d (truncation error of the estimate in [0, 1/16)).
module QDS (
  input  logic [6:0] w,
  input  logic [2:0] div,
  output logic [4:0] q
);
  logic signed [6:0] y, m2, m1, m0, mn1;

  assign y = w;

  always_comb begin
    m2 = 7'sd12; m1 = 7'sd4; m0 = -7'sd4; mn1 = -7'sd13;
    case (div)
      3'd0: begin m2 = 7'sd12; m1 = 7'sd4; m0 = -7'sd4; mn1 = -7'sd13; end
      3'd1: begin m2 = 7'sd14; m1 = 7'sd4; m0 = -7'sd4; mn1 = -7'sd14; end
      3'd2: begin m2 = 7'sd16; m1 = 7'sd4; m0 = -7'sd4; mn1 = -7'sd16; end
      3'd3: begin m2 = 7'sd16; m1 = 7'sd6; m0 = -7'sd6; mn1 = -7'sd16; end
      3'd4: begin m2 = 7'sd18; m1 = 7'sd6; m0 = -7'sd6; mn1 = -7'sd18; end
      3'd5: begin m2 = 7'sd20; m1 = 7'sd6; m0 = -7'sd6; mn1 = -7'sd20; end
      3'd6: begin m2 = 7'sd20; m1 = 7'sd8; m0 = -7'sd8; mn1 = -7'sd22; end
      default: begin m2 = 7'sd24; m1 = 7'sd8; m0 = -7'sd8; mn1 = -7'sd24; end
    endcase
  end

  always_comb begin
    if (y >= m2)       q = 5'b10000;
    else if (y >= m1)  q = 5'b01000;
    else if (y >= m0)  q = 5'b00100;
    else if (y >= mn1) q = 5'b00010;
    else               q = 5'b00001;
  end

endmodule

// File: rtl/srt4_otf_conv.sv
// On-the-fly quotient conversion for radix-4 SRT digits.
// Ports:
//   clk    : clock
//   clear  : start of a new quotient (Q = 0, QM = -1)
//   load   : append the digit on q this cycle
//   q      : one-hot digit {+2,+1,0,-1,-2}
//   sel_qm : final residual negative, return QM instead of Q
//   quot   : selected quotient (modulo 2^XLEN)
module srt4_otf_conv
  import srt4_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               load,
  input  logic [QDS_Q_W-1:0] q,
  input  logic               sel_qm,
  output logic [XLEN-1:0]    quot
);
  // QM always equals Q - 1, so every update is a plain select-and-shift.
  logic [XLEN-1:0] q_reg, qm_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      q_reg  <= '0;
      qm_reg <= '1;
    end else if (load) begin
      case (1'b1)
        q[DIG_P2]: begin q_reg <= {q_reg[XLEN-3:0], 2'b10};  qm_reg <= {q_reg[XLEN-3:0], 2'b01};  end
        q[DIG_P1]: begin q_reg <= {q_reg[XLEN-3:0], 2'b01};  qm_reg <= {q_reg[XLEN-3:0], 2'b00};  end
        q[DIG_Z]:  begin q_reg <= {q_reg[XLEN-3:0], 2'b00};  qm_reg <= {qm_reg[XLEN-3:0], 2'b11}; end
        q[DIG_M1]: begin q_reg <= {qm_reg[XLEN-3:0], 2'b11}; qm_reg <= {qm_reg[XLEN-3:0], 2'b10}; end
        q[DIG_M2]: begin q_reg <= {qm_reg[XLEN-3:0], 2'b10}; qm_reg <= {qm_reg[XLEN-3:0], 2'b01}; end
        default:   begin q_reg <= q_reg; qm_reg <= qm_reg; end
      endcase
    end
  end

  assign quot = sel_qm ? qm_reg : q_reg;

endmodule

// File: rtl/srt4_divider.sv
// Iterative radix-4 SRT integer divider (RV32M/RV64M DIV/DIVU/REM/REMU).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   op                  : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend, divisor   : rs1, rs2
//   out_valid/out_ready : result handshake, result held until accepted
//   result              : quotient or remainder
//   flush               : only with SRT4_DIVIDER_FLUSH_EN; abandons the op
// Residual w is two's complement with XLEN+3 fraction bits (range [-1,1)).
// The dividend is placed so that after K digits the quotient is integral.
module srt4_divider
  import srt4_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
`ifdef SRT4_DIVIDER_FLUSH_EN
  ,
  input  logic            flush
`endif
);
  localparam int SW = $clog2(XLEN);
  localparam int RW = XLEN + 4;
  localparam int TW = XLEN + 6;

  state_e state, state_nxt;
  logic [1:0]            op_r;
  logic                  qsign, rsign;
  logic [XLEN-1:0]       a_mag, b_mag, d_r;
  logic [SW-1:0]         s_r, s_n, cnt;
  logic signed [RW-1:0]  w_r, w_next, w_fin;
  logic signed [TW-1:0]  t4, dd1, dd2;
  logic [QDS_W_W-1:0]    qds_w;
  logic [QDS_DIV_W-1:0]  qds_div;
  logic [QDS_Q_W-1:0]    qds_q;
  logic                  flush_i, accept, is_signed, a_neg, b_neg;
  logic                  div_zero, sgn_ovf, special, w_neg;
  logic [XLEN-1:0]       special_res, quot_u, rem_u, quot_s, rem_s;

`ifdef SRT4_DIVIDER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  function automatic logic [SW-1:0] lzc(input logic [XLEN-1:0] v);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < XLEN; i++)
      if (v[i]) n = SW'(XLEN - 1 - i);
    return n;
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  // Request decode (IDLE)
  assign accept    = in_valid && (state == S_IDLE) && !flush_i;
  assign is_signed = (op == OP_DIV) || (op == OP_REM);
  assign a_neg     = is_signed && dividend[XLEN-1];
  assign b_neg     = is_signed && divisor[XLEN-1];
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  assign special   = div_zero || sgn_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = op[1] ? dividend : '1;
    else if (sgn_ovf) special_res = op[1] ? '0 : dividend;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = special ? S_DONE : S_NORM;
      end
      S_NORM:  state_nxt = S_ITER;
      S_ITER:  if (cnt == SW'(1)) state_nxt = S_POST;
      S_POST:  state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept && special)
        result <= special_res;
      else if (state == S_POST)
        result <= op_r[1] ? rem_s : quot_s;
    end
  end

  // Normalisation (NORM): K = floor((s+1)/2)+1 digits cover a quotient of
  // up to s+1 bits with w0 <= 1/4; odd s drops the extra left shift.
  assign s_n = lzc(b_mag);

  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= op;
      qsign <= a_neg ^ b_neg;
      rsign <= a_neg;
      a_mag <= apply_sign(dividend, a_neg);
      b_mag <= apply_sign(divisor, b_neg);
    end
    if (state == S_NORM) begin
      s_r <= s_n;
      d_r <= b_mag << s_n;
      cnt <= SW'((int'(s_n) + 1) / 2 + 1);
      w_r <= s_n[0] ? {4'b0000, a_mag} : {3'b000, a_mag, 1'b0};
    end else if (state == S_ITER) begin
      w_r <= w_next;
      cnt <= cnt - SW'(1);
    end
  end

  // Digit iteration (ITER): w <- 4w - q*d
  assign qds_w   = w_r[XLEN+3 -: QDS_W_W];
  assign qds_div = d_r[XLEN-2 -: QDS_DIV_W];

  QDS u_qds (
    .w   (qds_w),
    .div (qds_div),
    .q   (qds_q)
  );

  always_comb begin
    t4     = {w_r, 2'b00};
    dd1    = {3'b000, d_r, 3'b000};
    dd2    = {2'b00, d_r, 4'b0000};
    w_next = w_r;
    case (1'b1)
      qds_q[DIG_P2]: w_next = RW'(t4 - dd2);
      qds_q[DIG_P1]: w_next = RW'(t4 - dd1);
      qds_q[DIG_Z]:  w_next = RW'(t4);
      qds_q[DIG_M1]: w_next = RW'(t4 + dd1);
      qds_q[DIG_M2]: w_next = RW'(t4 + dd2);
      default:       w_next = w_r;
    endcase
  end

  srt4_otf_conv #(.XLEN(XLEN)) u_otf (
    .clk    (clk),
    .clear  (state == S_NORM),
    .load   (state == S_ITER),
    .q      (qds_q),
    .sel_qm (w_neg),
    .quot   (quot_u)
  );

  // Post-correction (POST): negative residual means the quotient is one too
  // large; the corrected residual scaled back by s+3 is the remainder.
  assign w_neg  = w_r[RW-1];
  assign w_fin  = w_neg ? w_r + $signed({1'b0, d_r, 3'b000}) : w_r;
  assign rem_u  = XLEN'(w_fin >> (int'(s_r) + 3));
  assign quot_s = apply_sign(quot_u, qsign);
  assign rem_s  = apply_sign(rem_u, rsign);

  a_digit_onehot: assert property (@(posedge clk) disable iff (rst)
    (state == S_ITER) |-> $onehot(qds_q));

endmodule

// File: tb/tb_srt4_divider.sv
// Directed testbench for srt4_divider (XLEN = 32).
// Drives inputs and samples outputs on the falling clock edge.
module tb_srt4_divider;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid;
  logic [1:0]  op;
  logic [31:0] dividend, divisor, result;
`ifdef SRT4_DIVIDER_FLUSH_EN
  logic        flush;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  srt4_divider #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef SRT4_DIVIDER_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for out_valid; lat counts cycles from
  // the accepting edge to the first cycle with out_valid high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          l;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; dividend = '0; divisor = '0;
`ifdef SRT4_DIVIDER_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    run_op(DIVU, 32'd100, 32'd7, r, l); check("divu_100_7", r, 32'd14); ack();
    check("post_ack_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_ack_out_valid", {31'b0, out_valid}, 32'd0);
    run_op(REMU, 32'd100, 32'd7, r, l); check("remu_100_7", r, 32'd2); ack();

    run_op(DIV, 32'hFFFF_FFF9, 32'd2, r, l); check("div_m7_2", r, 32'hFFFF_FFFD); ack();
    run_op(REM, 32'hFFFF_FFF9, 32'd2, r, l); check("rem_m7_2", r, 32'hFFFF_FFFF); ack();
    run_op(REM, 32'd7, 32'hFFFF_FFFE, r, l); check("rem_7_m2", r, 32'd1); ack();
    run_op(DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, r, l); check("div_m100_m7", r, 32'd14); ack();
    run_op(REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, r, l); check("rem_m100_m7", r, 32'hFFFF_FFFE); ack();
    run_op(DIV, 32'h7FFF_FFFF, 32'd3, r, l); check("div_max_3", r, 32'h2AAA_AAAA); ack();
    run_op(REMU, 32'hDEAD_BEEF, 32'h0000_1000, r, l); check("remu_pow2", r, 32'h0000_0EEF); ack();
    run_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0000, r, l); check("divu_big_div", r, 32'd1); ack();
    run_op(REMU, 32'hFFFF_FFFF, 32'h8000_0000, r, l); check("remu_big_div", r, 32'h7FFF_FFFF); ack();

    run_op(DIV, 32'h0000_1234, 32'd0, r, l);
    check("div_by_zero", r, 32'hFFFF_FFFF); check("div_by_zero_lat", 32'(l), 32'd1); ack();
    run_op(REM, 32'h0000_1234, 32'd0, r, l);
    check("rem_by_zero", r, 32'h0000_1234); check("rem_by_zero_lat", 32'(l), 32'd1); ack();

    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, l);
    check("div_ovf", r, 32'h8000_0000); check("div_ovf_lat", 32'(l), 32'd1); ack();
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, r, l); check("rem_ovf", r, 32'd0); ack();

    // Hold: consumer stalls for 5 cycles while a new request is presented.
    run_op(DIVU, 32'd1000, 32'd10, r, l);
    in_valid = 1'b1; op = DIVU; dividend = 32'd5; divisor = 32'd5;
    for (int i = 0; i < 5; i++) begin
      check("hold_result", result, 32'd100);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    ack();

    // Reset in the middle of the digit loop.
    @(negedge clk);
    op = DIVU; dividend = 32'hFFFF_FFFF; divisor = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_iter_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_iter_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (25) @(negedge clk);
    check("rst_iter_no_result", {31'b0, out_valid}, 32'd0);
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, r, l);
    check("divu_max_1", r, 32'hFFFF_FFFF); check("divu_max_1_lat", 32'(l), 32'd20); ack();

`ifdef SRT4_DIVIDER_FLUSH_EN
    @(negedge clk);
    op = DIVU; dividend = 32'hFFFF_FFFF; divisor = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (25) @(negedge clk);
    check("flush_no_result", {31'b0, out_valid}, 32'd0);
    run_op(DIVU, 32'd100, 32'd7, r, l); check("flush_next_op", r, 32'd14); ack();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
